intl_trip_ctrl: RTL and testbench

Interlock trip sequencer. Sits between the MPS interlock status word and the power stage. It debounces and masks each interlock source, and on a fault sequences a safe shutdown: PWM off first, then the DC relay after a programmed delay. It latches first-fault and accumulated-fault words for EPICS/DSP and gates recovery behind an operator reset.

---
 rtl/intl_pkg.sv | 32 +++
 rtl/intl_filt.sv | 35 +++
 rtl/intl_trip_ctrl.sv | 126 ++++++++++++
 tb/tb_intl_trip_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intl_pkg.sv
// Shared definitions for the interlock trip sequencer: FSM encoding,
// source count and interlock status-word bit positions.
package intl_pkg;

  localparam int N_SRC = 16;

  localparam logic [1:0] ST_SAFE    = 2'd0;
  localparam logic [1:0] ST_RECOVER = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;
  localparam logic [1:0] ST_SHUTDN  = 2'd3;

  typedef enum logic [1:0] {
    SAFE    = ST_SAFE,
    RECOVER = ST_RECOVER,
    RUN     = ST_RUN,
    SHUTDN  = ST_SHUTDN
  } fsm_state_t;

  localparam int BIT_EXT1    = 0;
  localparam int BIT_EXT2    = 1;
  localparam int BIT_EXT3    = 2;
  localparam int BIT_EXT4    = 3;
  localparam int BIT_OC      = 4;
  localparam int BIT_POC     = 5;
  localparam int BIT_OV      = 6;
  localparam int BIT_OH      = 7;
  localparam int BIT_SW_UV   = 8;
  localparam int BIT_SW_OV   = 9;
  localparam int BIT_SW_OC   = 10;
  localparam int BIT_SYS_RST = 15;

endpackage

// File: rtl/intl_filt.sv
// Single-source interlock debounce: counts consecutive active cycles and
// flags a filtered fault once the count reaches the shared threshold.
module intl_filt #(
  parameter int FILT_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_raw,
  input  logic              i_en,
  input  logic [FILT_W-1:0] i_thr,
  output logic              o_flt
);

  logic              act;
  logic [FILT_W-1:0] cnt;

  function automatic logic [FILT_W-1:0] sat_inc(input logic [FILT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign act   = i_raw & i_en;
  // Combinational compare so a zero threshold passes the fault straight through.
  assign o_flt = act & (cnt >= i_thr);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt <= '0;
    end else if (act) begin
      cnt <= sat_inc(cnt);
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/intl_trip_ctrl.sv
// Interlock trip sequencer: debounced/masked fault detection, PWM-then-relay
// shutdown sequencing, fault latching and operator-reset gated recovery.
module intl_trip_ctrl #(
  parameter int N_SRC  = intl_pkg::N_SRC,
  parameter int FILT_W = 16,
  parameter int DLY_W  = 20
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_SRC-1:0]  i_intl_state,
  input  logic [N_SRC-1:0]  i_intl_mask,
  input  logic [FILT_W-1:0] i_filt_cnt,
  input  logic [DLY_W-1:0]  i_relay_delay,
  input  logic              i_run_cmd,
  input  logic              i_intl_rst,
  output logic              o_pwm_en,
  output logic              o_relay_on,
  output logic              o_trip,
  output logic [N_SRC-1:0]  o_first_fault,
  output logic [N_SRC-1:0]  o_latched,
  output logic              o_rst_reject,
  output logic [1:0]        o_fsm
);

  import intl_pkg::*;

  fsm_state_t        state;
  fsm_state_t        n_state;
  logic [N_SRC-1:0]  flt;
  logic              any_flt;
  logic [DLY_W-1:0]  dly;
  logic [DLY_W-1:0]  dly_n;
  logic              dly_done;
  logic              rst_low_q;
  logic              rst_rise;
  logic              rst_accept;
  logic              rst_reject;
  logic              enter_shutdn;

  for (genvar g = 0; g < N_SRC; g++) begin : g_filt
    intl_filt #(
      .FILT_W (FILT_W)
    ) u_filt (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_raw  (i_intl_state[g]),
      .i_en   (i_intl_mask[g]),
      .i_thr  (i_filt_cnt),
      .o_flt  (flt[g])
    );
  end

  assign any_flt  = |flt;
  assign dly_done = (dly == i_relay_delay);

  // rst_low_q records "reset input was low last cycle"; clearing it on async
  // reset keeps a reset input held high through power-up from looking like an edge.
  assign rst_rise     = i_intl_rst & rst_low_q;
  assign rst_accept   = (state == SAFE) & rst_rise & ~any_flt;
  assign rst_reject   = (state == SAFE) & rst_rise & any_flt;
  assign enter_shutdn = (n_state == SHUTDN) & (state != SHUTDN);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= SAFE;
    end else begin
      state <= n_state;
    end
  end

  always_comb begin
    n_state = state;
    case (state)
      SAFE:    if (rst_accept) n_state = RECOVER;
      RECOVER: begin
        if (any_flt)       n_state = SHUTDN;
        else if (dly_done) n_state = RUN;
      end
      RUN:     if (any_flt) n_state = SHUTDN;
      SHUTDN:  if (dly_done) n_state = SAFE;
      default: n_state = SAFE;
    endcase
  end

  // Dwell counter restarts on every state change, so a fault during
  // RECOVER gives SHUTDN its full dwell.
  always_comb begin
    dly_n = '0;
    if ((n_state == state) && ((state == RECOVER) || (state == SHUTDN))) begin
      dly_n = dly + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      dly           <= '0;
      rst_low_q     <= 1'b0;
      o_pwm_en      <= 1'b0;
      o_relay_on    <= 1'b0;
      o_rst_reject  <= 1'b0;
      o_trip        <= 1'b0;
      o_first_fault <= '0;
      o_latched     <= '0;
    end else begin
      dly          <= dly_n;
      rst_low_q    <= ~i_intl_rst;
      o_relay_on   <= (n_state != SAFE);
      o_pwm_en     <= (n_state == RUN) & i_run_cmd;
      o_rst_reject <= rst_reject;
      if (rst_accept) begin
        o_trip        <= 1'b0;
        o_first_fault <= '0;
        o_latched     <= '0;
      end else begin
        o_latched <= o_latched | flt;
        if (enter_shutdn) begin
          o_trip        <= 1'b1;
          o_first_fault <= flt;
        end
      end
    end
  end

  assign o_fsm = state;

endmodule

// File: tb/tb_intl_trip_ctrl.sv
// Self-checking bench for intl_trip_ctrl: directed sequences plus randomized
// traffic compared each cycle against a behavioural model of the sequencer.
module tb_intl_trip_ctrl;

  localparam int N = 16;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [15:0] i_intl_state;
  logic [15:0] i_intl_mask;
  logic [15:0] i_filt_cnt;
  logic [19:0] i_relay_delay;
  logic        i_run_cmd;
  logic        i_intl_rst;
  logic        o_pwm_en;
  logic        o_relay_on;
  logic        o_trip;
  logic [15:0] o_first_fault;
  logic [15:0] o_latched;
  logic        o_rst_reject;
  logic [1:0]  o_fsm;

  int n_chk = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  intl_trip_ctrl #(
    .N_SRC  (16),
    .FILT_W (16),
    .DLY_W  (20)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_intl_state  (i_intl_state),
    .i_intl_mask   (i_intl_mask),
    .i_filt_cnt    (i_filt_cnt),
    .i_relay_delay (i_relay_delay),
    .i_run_cmd     (i_run_cmd),
    .i_intl_rst    (i_intl_rst),
    .o_pwm_en      (o_pwm_en),
    .o_relay_on    (o_relay_on),
    .o_trip        (o_trip),
    .o_first_fault (o_first_fault),
    .o_latched     (o_latched),
    .o_rst_reject  (o_rst_reject),
    .o_fsm         (o_fsm)
  );

  // Behavioural model: run lengths per source, phase 0..3 and a remaining-dwell countdown.
  int          m_run [N];
  int          m_phase;
  int          m_remain;
  bit          m_low_seen;
  logic        m_pwm, m_relay, m_trip, m_rej;
  logic [15:0] m_first, m_latched;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) m_run[i] = 0;
    m_phase    = 0;
    m_remain   = 0;
    m_low_seen = 1'b0;
    m_pwm      = 1'b0;
    m_relay    = 1'b0;
    m_trip     = 1'b0;
    m_rej      = 1'b0;
    m_first    = '0;
    m_latched  = '0;
  endfunction

  function automatic void model_edge();
    logic [15:0] flt;
    bit          rise;
    bit          accept;
    int          nphase;
    flt = '0;
    for (int i = 0; i < N; i++) begin
      if (i_intl_state[i] && i_intl_mask[i] && (m_run[i] >= int'(i_filt_cnt))) flt[i] = 1'b1;
    end
    rise   = i_intl_rst && m_low_seen;
    accept = (m_phase == 0) && rise && (flt == 0);
    nphase = m_phase;
    case (m_phase)
      0: if (accept) nphase = 1;
      1: begin
        if (flt != 0) nphase = 3;
        else if (m_remain == 0) nphase = 2;
      end
      2: if (flt != 0) nphase = 3;
      default: if (m_remain == 0) nphase = 0;
    endcase
    m_rej = (m_phase == 0) && rise && (flt != 0);
    if (accept) begin
      m_trip    = 1'b0;
      m_first   = '0;
      m_latched = '0;
    end else begin
      m_latched = m_latched | flt;
      if (nphase == 3 && m_phase != 3) begin
        m_trip  = 1'b1;
        m_first = flt;
      end
    end
    m_relay = (nphase != 0);
    m_pwm   = (nphase == 2) && i_run_cmd;
    if (nphase != m_phase) m_remain = int'(i_relay_delay);
    else if (m_phase == 1 || m_phase == 3) m_remain--;
    for (int i = 0; i < N; i++) begin
      if (i_intl_state[i] && i_intl_mask[i]) m_run[i] = (m_run[i] < 65535) ? m_run[i] + 1 : 65535;
      else m_run[i] = 0;
    end
    m_low_seen = !i_intl_rst;
    m_phase    = nphase;
  endfunction

  task automatic compare_all();
    chk("fsm",     32'(o_fsm),         32'(m_phase));
    chk("pwm_en",  32'(o_pwm_en),      32'(m_pwm));
    chk("relay",   32'(o_relay_on),    32'(m_relay));
    chk("trip",    32'(o_trip),        32'(m_trip));
    chk("reject",  32'(o_rst_reject),  32'(m_rej));
    chk("first",   32'(o_first_fault), 32'(m_first));
    chk("latched", 32'(o_latched),     32'(m_latched));
  endtask

  task automatic step();
    model_edge();
    @(posedge i_clk);
    #1;
    compare_all();
  endtask

  task automatic async_reset();
    #2 i_rst = 1'b0;
    #1;
    model_reset();
    chk("arst_fsm",   32'(o_fsm),      32'd0);
    chk("arst_relay", 32'(o_relay_on), 32'd0);
    chk("arst_pwm",   32'(o_pwm_en),   32'd0);
    chk("arst_trip",  32'(o_trip),     32'd0);
    compare_all();
    @(posedge i_clk);
    @(posedge i_clk);
    #3 i_rst = 1'b1;
    #1;
    compare_all();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    i_rst         = 1'b0;
    i_intl_state  = '0;
    i_intl_mask   = 16'hFFFF;
    i_filt_cnt    = 16'd0;
    i_relay_delay = 20'd4;
    i_run_cmd     = 1'b0;
    i_intl_rst    = 1'b0;
    repeat (3) @(posedge i_clk);
    #3 i_rst = 1'b1;
    model_reset();
    #1;
    chk("por_fsm",   32'(o_fsm),      32'd0);
    chk("por_relay", 32'(o_relay_on), 32'd0);
    chk("por_pwm",   32'(o_pwm_en),   32'd0);
    compare_all();
    step();
    step();

    // Power-up and arm
    i_run_cmd  = 1'b1;
    i_intl_rst = 1'b1;
    step();
    chk("arm_relay", 32'(o_relay_on), 32'd1);
    chk("arm_fsm",   32'(o_fsm),      32'd1);
    i_intl_rst = 1'b0;
    repeat (4) step();
    chk("arm_wait_fsm", 32'(o_fsm), 32'd1);
    step();
    chk("arm_run_fsm", 32'(o_fsm),    32'd2);
    chk("arm_pwm",     32'(o_pwm_en), 32'd1);
    i_run_cmd = 1'b0;
    step();
    chk("runcmd_off", 32'(o_pwm_en), 32'd0);
    i_run_cmd = 1'b1;
    step();
    chk("runcmd_on", 32'(o_pwm_en), 32'd1);

    // Debounce
    i_filt_cnt   = 16'd3;
    i_intl_state = 16'h0010;
    repeat (3) step();
    i_intl_state = '0;
    step();
    chk("deb3_fsm",  32'(o_fsm),  32'd2);
    chk("deb3_trip", 32'(o_trip), 32'd0);
    i_intl_state = 16'h0010;
    repeat (4) step();
    chk("deb4_fsm",   32'(o_fsm),         32'd3);
    chk("deb4_first", 32'(o_first_fault), 32'h0010);
    chk("deb4_pwm",   32'(o_pwm_en),      32'd0);
    i_intl_state = '0;
    repeat (4) step();
    chk("deb_relay_hold", 32'(o_relay_on), 32'd1);
    step();
    chk("deb_relay_off", 32'(o_relay_on), 32'd0);
    i_intl_rst = 1'b1;
    step();
    chk("acc_fsm",     32'(o_fsm),     32'd1);
    chk("acc_latched", 32'(o_latched), 32'd0);
    chk("acc_trip",    32'(o_trip),    32'd0);
    i_intl_rst = 1'b0;
    repeat (5) step();

    // Shutdown on bit 9
    i_filt_cnt   = 16'd0;
    i_intl_state = 16'h0200;
    step();
    chk("sd_pwm", 32'(o_pwm_en), 32'd0);
    chk("sd_fsm", 32'(o_fsm),    32'd3);
    i_intl_state = '0;
    repeat (4) step();
    chk("sd_relay_hold", 32'(o_relay_on), 32'd1);
    step();
    chk("sd_relay_off", 32'(o_relay_on), 32'd0);
    chk("sd_trip",      32'(o_trip),     32'd1);
    chk("sd_latched",   32'(o_latched),  32'h0200);

    // Reset refused then accepted
    i_intl_state = 16'h0001;
    step();
    i_intl_rst = 1'b1;
    step();
    chk("rej_pulse", 32'(o_rst_reject), 32'd1);
    chk("rej_fsm",   32'(o_fsm),        32'd0);
    i_intl_rst = 1'b0;
    step();
    chk("rej_clear", 32'(o_rst_reject), 32'd0);
    i_intl_state = '0;
    step();
    i_intl_rst = 1'b1;
    step();
    chk("acc2_latched", 32'(o_latched),     32'd0);
    chk("acc2_trip",    32'(o_trip),        32'd0);
    chk("acc2_first",   32'(o_first_fault), 32'd0);
    chk("acc2_fsm",     32'(o_fsm),         32'd1);
    i_intl_rst = 1'b0;
    repeat (5) step();

    // Mask and simultaneous faults
    i_intl_mask  = 16'hFFFE;
    i_intl_state = 16'h0001;
    repeat (3) step();
    chk("mask_fsm",  32'(o_fsm),  32'd2);
    chk("mask_trip", 32'(o_trip), 32'd0);
    i_intl_state = 16'h0120;
    step();
    chk("simul_first", 32'(o_first_fault), 32'h0120);
    i_intl_state = '0;
    i_intl_mask  = 16'hFFFF;
    repeat (5) step();
    chk("simul_safe", 32'(o_fsm), 32'd0);

    // Fault during RECOVER at dly=2
    i_intl_rst = 1'b1;
    step();
    i_intl_rst = 1'b0;
    repeat (2) step();
    i_intl_state = 16'h0010;
    step();
    chk("rec_fsm",   32'(o_fsm),         32'd3);
    chk("rec_first", 32'(o_first_fault), 32'h0010);
    i_intl_state = '0;
    repeat (4) step();
    chk("rec_dwell", 32'(o_fsm), 32'd3);
    step();
    chk("rec_safe", 32'(o_fsm), 32'd0);

    // Async reset mid-SHUTDN
    i_intl_rst = 1'b1;
    step();
    i_intl_rst = 1'b0;
    repeat (5) step();
    i_intl_state = 16'h0040;
    step();
    i_intl_state = '0;
    repeat (2) step();
    chk("pre_arst_fsm", 32'(o_fsm), 32'd3);
    i_intl_rst = 1'b1;
    async_reset();
    repeat (3) step();
    chk("hold_no_arm",   32'(o_fsm),      32'd0);
    chk("hold_no_relay", 32'(o_relay_on), 32'd0);
    i_intl_rst = 1'b0;
    step();
    i_intl_rst = 1'b1;
    step();
    chk("rearm_fsm", 32'(o_fsm), 32'd1);
    i_intl_rst = 1'b0;

    // Randomized traffic
    for (int seg = 0; seg < 8; seg++) begin
      i_filt_cnt  = 16'($urandom_range(0, 3));
      i_intl_mask = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'($urandom);
      for (int c = 0; c < 300; c++) begin
        if ((m_phase == 0 || m_phase == 2) && $urandom_range(0, 49) == 0)
          i_relay_delay = 20'($urandom_range(0, 6));
        if ($urandom_range(0, 9) == 0) begin
          case ($urandom_range(0, 3))
            0, 1:    i_intl_state = '0;
            2:       i_intl_state = 16'(1) << $urandom_range(0, 15);
            default: i_intl_state = 16'($urandom) & 16'($urandom);
          endcase
        end
        if ($urandom_range(0, 5) == 0) i_intl_rst = ~i_intl_rst;
        if ($urandom_range(0, 7) == 0) i_run_cmd = ~i_run_cmd;
        if ($urandom_range(0, 399) == 0) async_reset();
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
